// File: rtl/gen_sweep_ctrl_pkg.sv
// gen_pkg: shared definitions for the function-generator control blocks.
//   - waveform mode codes driven to the generator driver
//   - sweep sequencer state encoding
//   - default word widths
package gen_pkg;

  localparam int FREQ_W_DEF  = 32;
  localparam int DWELL_W_DEF = 32;

  localparam logic [1:0] MODE_SQUARE = 2'b00;
  localparam logic [1:0] MODE_SINE   = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_SAW    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DWELL = 3'd2,
    STEP  = 3'd3,
    FIN   = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/gen_sweep_ctrl_if.sv
// gen_sweep_ctrl_if: config/control/driver bundle of the sweep sequencer.
//   master : user/config side (drives cfg_*, start, abort)
//   slave  : sequencer side (drives cfg_ready, mode, freq, freq_stb, busy, done)
interface gen_sweep_ctrl_if #(
  parameter int FREQ_W  = gen_pkg::FREQ_W_DEF,
  parameter int DWELL_W = gen_pkg::DWELL_W_DEF
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop;
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [FREQ_W-1:0]  freq;
  logic               freq_stb;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_mode, cfg_start_freq, cfg_stop_freq, cfg_step,
           cfg_dwell, cfg_loop, start, abort,
    input  cfg_ready, mode, freq, freq_stb, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_start_freq, cfg_stop_freq, cfg_step,
           cfg_dwell, cfg_loop, start, abort,
    output cfg_ready, mode, freq, freq_stb, busy, done
  );

endinterface

// File: rtl/gen_sweep_ctrl_step_calc.sv
// sweep_step_calc: combinational next-frequency calculation for a sweep step.
//   i_freq   : current frequency
//   i_step   : step magnitude
//   i_stop   : final frequency of the sweep (clamp target)
//   i_dir_up : 1 = add step, 0 = subtract step
//   o_next   : freq +/- step, clamped to i_stop on overshoot or wrap
module sweep_step_calc #(
  parameter int FREQ_W = gen_pkg::FREQ_W_DEF
) (
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [FREQ_W-1:0] i_step,
  input  logic [FREQ_W-1:0] i_stop,
  input  logic              i_dir_up,
  output logic [FREQ_W-1:0] o_next
);

  // One extra bit catches carry (up) and borrow (down) so a sweep
  // near the ends of the range never wraps to the far side.
  logic [FREQ_W:0] w_sum;
  logic [FREQ_W:0] w_diff;
  logic            w_clamp_up;
  logic            w_clamp_dn;

  assign w_sum      = {1'b0, i_freq} + {1'b0, i_step};
  assign w_diff     = {1'b0, i_freq} - {1'b0, i_step};
  assign w_clamp_up = w_sum[FREQ_W]  || (w_sum[FREQ_W-1:0]  > i_stop);
  assign w_clamp_dn = w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] < i_stop);

  always_comb begin
    o_next = i_freq;
    if (i_dir_up) begin
      o_next = w_clamp_up ? i_stop : w_sum[FREQ_W-1:0];
    end else begin
      o_next = w_clamp_dn ? i_stop : w_diff[FREQ_W-1:0];
    end
  end

endmodule

// File: rtl/gen_sweep_ctrl.sv
// gen_sweep_ctrl: frequency-sweep sequencer feeding the generator driver.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : gen_sweep_ctrl_if.slave
//          cfg_* handshake (accepted in IDLE only), start/abort control,
//          mode/freq/freq_stb to the driver, busy/done status.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; config accepted here only
// LOAD  | apply start_freq and mode, load dwell counter
// DWELL | hold current frequency while the counter runs down to 0
// STEP  | apply next (clamped) frequency, reload dwell counter
// FIN   | end of sweep: restart when looping, else pulse done
module gen_sweep_ctrl
  import gen_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic             clk,
  input logic             rst,
  gen_sweep_ctrl_if.slave bus
);

  sweep_state_t       r_state;
  sweep_state_t       w_state_nxt;

  logic [FREQ_W-1:0]  r_start;
  logic [FREQ_W-1:0]  r_stop;
  logic [FREQ_W-1:0]  r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_mode_cfg;
  logic               r_loop;

  logic               r_dir_up;
  logic [DWELL_W-1:0] r_cnt;
  logic [FREQ_W-1:0]  r_freq;
  logic [1:0]         r_mode;
  logic               r_stb;
  logic               r_done;
  logic               r_busy;

  logic               w_cfg_ready;
  logic               w_cfg_xfer;
  logic [DWELL_W-1:0] w_dwell_m1;
  logic [FREQ_W-1:0]  w_next;
  logic               w_load;
  logic               w_step;
  logic               w_done_nxt;
  logic               w_busy_nxt;

  assign w_cfg_ready = (r_state == IDLE);
  assign w_cfg_xfer  = bus.cfg_valid && w_cfg_ready;
  // A dwell of 0 is held like a dwell of 1.
  assign w_dwell_m1  = (r_dwell == '0) ? '0 : (r_dwell - {{(DWELL_W-1){1'b0}}, 1'b1});

  sweep_step_calc #(.FREQ_W(FREQ_W)) u_step_calc (
    .i_freq   (r_freq),
    .i_step   (r_step),
    .i_stop   (r_stop),
    .i_dir_up (r_dir_up),
    .o_next   (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = LOAD;
          w_busy_nxt  = 1'b1;
        end
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = DWELL;
      end
      DWELL: begin
        if (r_cnt == '0) begin
          w_state_nxt = ((r_freq == r_stop) || (r_step == '0)) ? FIN : STEP;
        end
      end
      STEP: begin
        w_step      = 1'b1;
        w_state_nxt = DWELL;
      end
      FIN: begin
        if (r_loop) begin
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over every other transition and suppresses any update.
    if (bus.abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start    <= '0;
      r_stop     <= '0;
      r_step     <= '0;
      r_dwell    <= '0;
      r_mode_cfg <= '0;
      r_loop     <= 1'b0;
    end else if (w_cfg_xfer) begin
      r_start    <= bus.cfg_start_freq;
      r_stop     <= bus.cfg_stop_freq;
      r_step     <= bus.cfg_step;
      r_dwell    <= bus.cfg_dwell;
      r_mode_cfg <= bus.cfg_mode;
      r_loop     <= bus.cfg_loop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir_up <= 1'b1;
      r_cnt    <= '0;
      r_freq   <= '0;
      r_mode   <= '0;
      r_stb    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_stb  <= w_load || w_step;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
      if (w_load) begin
        r_freq   <= r_start;
        r_mode   <= r_mode_cfg;
        r_dir_up <= (r_stop >= r_start);
      end else if (w_step) begin
        r_freq <= w_next;
      end
      if (w_load || w_step) begin
        r_cnt <= w_dwell_m1;
      end else if ((r_state == DWELL) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.mode      = r_mode;
  assign bus.freq      = r_freq;
  assign bus.freq_stb  = r_stb;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_gen_sweep_ctrl.sv
// tb_gen_sweep_ctrl: directed + randomized bench for gen_sweep_ctrl against
// a list-based sweep model (expected frequency list and strobe timing).
module tb_gen_sweep_ctrl;
  import gen_pkg::*;

  localparam int FW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gen_sweep_ctrl_if #(.FREQ_W(FW), .DWELL_W(DW)) bus ();

  gen_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_start, m_stop, m_step, m_dwell;
  logic [1:0]  m_mode;
  logic        m_loop;
  longint      exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frequency list of one pass: start, then +/- step with a clamp
  // at stop, until stop is reached (or immediately when step is 0).
  function automatic void build_exp();
    longint f, st, sp;
    bit     up;
    exp_q.delete();
    f  = longint'(m_start);
    st = longint'(m_stop);
    sp = longint'(m_step);
    up = (st >= f);
    exp_q.push_back(f);
    while (f != st && sp != 0) begin
      if (up) begin
        f = f + sp;
        if (f > st) f = st;
      end else begin
        f = f - sp;
        if (f < st) f = st;
      end
      exp_q.push_back(f);
    end
  endfunction

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] sp,
                         input logic [31:0] d, input logic [1:0] md, input logic lp);
    m_start = s;  m_stop = e;  m_step = sp;  m_dwell = d;  m_mode = md;  m_loop = lp;
    bus.cfg_start_freq = s;
    bus.cfg_stop_freq  = e;
    bus.cfg_step       = sp;
    bus.cfg_dwell      = d;
    bus.cfg_mode       = md;
    bus.cfg_loop       = lp;
  endtask

  // One non-looping sweep. Start is sampled on the edge after the first
  // negedge; k counts negedge samples after that edge. First strobe at k=2,
  // strobes every dwell+1 cycles, done dwell+1 cycles after the last strobe.
  task automatic run_and_check(input string tag, input bit drive_cfg, input bit junk);
    int     d, k, budget, done_k, n_done;
    int     stb_k[$];
    longint stb_f[$];
    build_exp();
    d      = (m_dwell == 0) ? 1 : int'(m_dwell);
    budget = 2 + exp_q.size() * (d + 1) + 8;
    done_k = -1;
    n_done = 0;
    k      = 0;
    @(negedge clk);
    bus.cfg_valid = drive_cfg;
    bus.start     = 1'b1;
    while (k < budget) begin
      @(negedge clk);
      k++;
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      if (junk && k == 3) begin
        bus.cfg_valid      = 1'b1;
        bus.cfg_start_freq = $urandom;
        bus.cfg_stop_freq  = $urandom;
        bus.cfg_step       = $urandom_range(1, 9);
        bus.cfg_dwell      = $urandom_range(5, 9);
        bus.cfg_mode       = ~m_mode;
        bus.cfg_loop       = 1'b1;
      end
      if (k == 1) chk({tag, ".busy_load"}, longint'(bus.busy), 1);
      if (bus.freq_stb) begin
        stb_k.push_back(k);
        stb_f.push_back(longint'(bus.freq));
        chk({tag, ".mode"}, longint'(bus.mode), longint'(m_mode));
      end
      if (bus.done) begin
        n_done++;
        if (done_k < 0) done_k = k;
        chk({tag, ".busy_at_done"}, longint'(bus.busy), 0);
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    chk({tag, ".n_stb"}, longint'(stb_k.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < stb_f.size(); i++) begin
      chk($sformatf("%s.freq%0d", tag, i), stb_f[i], exp_q[i]);
      chk($sformatf("%s.t_stb%0d", tag, i), longint'(stb_k[i]), longint'(2 + i * (d + 1)));
    end
    chk({tag, ".n_done"}, longint'(n_done), 1);
    chk({tag, ".t_done"}, longint'(done_k), longint'(2 + exp_q.size() * (d + 1)));
    chk({tag, ".cfg_ready"}, longint'(bus.cfg_ready), 1);
    chk({tag, ".freq_hold"}, longint'(bus.freq), exp_q[exp_q.size() - 1]);
  endtask

  initial begin
    int     up, span, idx, n_done, t0, exp_stb;
    longint last_f;
    logic [31:0] s, e;

    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    set_cfg(0, 0, 0, 0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst.freq",      longint'(bus.freq), 0);
    chk("rst.mode",      longint'(bus.mode), 0);
    chk("rst.busy",      longint'(bus.busy), 0);
    chk("rst.done",      longint'(bus.done), 0);
    chk("rst.stb",       longint'(bus.freq_stb), 0);
    chk("rst.cfg_ready", longint'(bus.cfg_ready), 1);
    rst = 1'b0;

    set_cfg(1000, 1300, 100, 3, MODE_SINE, 1'b0);
    run_and_check("up", 1'b1, 1'b0);
    set_cfg(500, 120, 200, 1, MODE_TRI, 1'b0);
    run_and_check("down_clamp", 1'b1, 1'b0);
    set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2, MODE_SAW, 1'b0);
    run_and_check("ovf_clamp", 1'b1, 1'b0);
    set_cfg(700, 900, 0, 2, MODE_SQUARE, 1'b0);
    run_and_check("step0", 1'b1, 1'b0);
    set_cfg(50, 80, 10, 0, MODE_SINE, 1'b0);
    run_and_check("dwell0", 1'b1, 1'b0);
    set_cfg(42, 42, 5, 2, MODE_TRI, 1'b0);
    run_and_check("start_eq_stop", 1'b1, 1'b0);

    set_cfg(100, 400, 100, 2, MODE_SAW, 1'b0);
    run_and_check("cfg_busy", 1'b1, 1'b1);
    run_and_check("cfg_kept", 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      up   = $urandom_range(0, 1);
      span = $urandom_range(0, 800);
      if (up != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          e = 32'hFFFF_FFFF;
          s = e - 32'($urandom_range(0, 500));
        end else begin
          s = $urandom_range(0, 32'hFFFF_0000);
          e = s + 32'(span);
        end
      end else begin
        s = $urandom_range(1000, 32'hFFFF_FFFF);
        e = s - 32'(span);
      end
      set_cfg(s, e, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(50, 400)),
              32'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'b0);
      run_and_check($sformatf("rnd%0d", it), 1'b1, 1'b0);
    end

    // Looping sweep: pass period is 2*dwell+3 (two values, STEP, FIN, LOAD).
    set_cfg(10, 20, 10, 2, MODE_TRI, 1'b1);
    build_exp();
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.start     = 1'b1;
    idx = 0;  n_done = 0;  last_f = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.start     = 1'b0;
      if (bus.freq_stb) begin
        chk($sformatf("loop.freq%0d", idx), longint'(bus.freq), exp_q[idx % exp_q.size()]);
        idx++;
      end
      if (bus.done) n_done++;
      if (!bus.busy) chk("loop.busy", longint'(bus.busy), 1);
    end
    exp_stb = 0;
    for (int j = 0; j < 10; j++) begin
      t0 = 2 + j * (2 * 2 + 3);
      if (t0 <= 30) exp_stb++;
      if (t0 + 3 <= 30) exp_stb++;
    end
    chk("loop.n_stb", longint'(idx), longint'(exp_stb));
    chk("loop.n_done", longint'(n_done), 0);

    n_done = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.freq_stb) begin
        n_done = 0;
        break;
      end
    end
    chk("abort.found_stb", longint'(n_done), 0);
    last_f    = longint'(bus.freq);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort.busy",      longint'(bus.busy), 0);
    chk("abort.freq_hold", longint'(bus.freq), last_f);
    chk("abort.done",      longint'(bus.done), 0);
    chk("abort.stb",       longint'(bus.freq_stb), 0);
    chk("abort.cfg_ready", longint'(bus.cfg_ready), 1);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done || bus.freq_stb || bus.busy) n_done++;
    end
    chk("abort.quiet", longint'(n_done), 0);

    set_cfg(300, 600, 100, 1, MODE_SINE, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    chk("start_abort.busy",  longint'(bus.busy), 0);
    chk("start_abort.ready", longint'(bus.cfg_ready), 1);
    chk("start_abort.stb",   longint'(bus.freq_stb), 0);
    @(negedge clk);
    chk("start_abort.busy2", longint'(bus.busy), 0);
    chk("start_abort.stb2",  longint'(bus.freq_stb), 0);

    set_cfg(1000, 5000, 100, 3, MODE_SAW, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid.busy_before", longint'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.freq",      longint'(bus.freq), 0);
    chk("rstmid.mode",      longint'(bus.mode), 0);
    chk("rstmid.busy",      longint'(bus.busy), 0);
    chk("rstmid.done",      longint'(bus.done), 0);
    chk("rstmid.stb",       longint'(bus.freq_stb), 0);
    chk("rstmid.cfg_ready", longint'(bus.cfg_ready), 1);
    rst = 1'b0;
    // Config registers were cleared, so a bare start sweeps 0 -> 0 once.
    m_start = 0;  m_stop = 0;  m_step = 0;  m_dwell = 0;  m_mode = 2'b00;  m_loop = 1'b0;
    run_and_check("post_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
